regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single write port of the integer register file between two writeback requesters, for example ALU writeback and load-unit writeback. It grants one request per cycle using round-robin priority, with a valid/ready handshake. Each accepted write is registered for one cycle, then drives a one-hot per-register `load` vector and a shared data word into the bank of `n_bits_register` instances. The same registered stage is exported as a forwarding source, and stall cycles caused by contention are counted.

## Interface
Parameters:
- WORDSIZE, 64, width of each register and of the write data
- ADDRSIZE, 5, width of a register address
- NREGS, 32, number of registers (must equal 2**ADDRSIZE)
- CNTSIZE, 16, width of the conflict counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- stall  input  1  pipeline freeze; while 1, no request is granted
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDRSIZE  requester 0 destination register
- req0_data  input  WORDSIZE  requester 0 write data
- req0_ready  output  1  requester 0 granted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  ADDRSIZE  requester 1 destination register
- req1_data  input  WORDSIZE  requester 1 write data
- req1_ready  output  1  requester 1 granted this cycle
- load_vec  output  NREGS  one-hot load strobe, bit i drives the register i `load`
- data_out  output  WORDSIZE  write word, drives every register `data_in`
- fwd_valid  output  1  the write stage holds a write
- fwd_addr  output  ADDRSIZE  write-stage address
- conflict_count  output  CNTSIZE  saturating count of contention cycles

## Operation
Handshake:
- A transfer occurs when reqN_valid && reqN_ready at a rising edge.
- A requester holds valid, addr and data stable until it sees ready.
- readyN is combinational from both valids, stall and the priority pointer. It never depends on readyN itself.

Grant:
- stall = 1: both ready = 0.
- Only one valid: that requester is granted.
- Both valid: grant the requester named by `prio` (0 or 1). The other sees ready = 0 and stays pending.
- `prio` update, whenever both are valid and stall = 0: it toggles to the non-granted requester. Otherwise it is unchanged.
- At most one ready is high in any cycle.

Write stage registers: wr_valid, wr_addr, wr_data.
- On a transfer: wr_valid <= 1; wr_addr and wr_data <= the granted requester's fields.
- With no transfer: wr_valid <= 0; wr_addr and wr_data hold.

Outputs from the stage:
- load_vec = one-hot(wr_addr) when wr_valid && wr_addr != 0, else all zeros.
- Register x0 is never loaded, but a write to address 0 is still accepted and handshaken.
- data_out = wr_data.
- fwd_valid = wr_valid && wr_addr != 0; fwd_addr = wr_addr.

Conflict counter:
- Increments by 1 on each edge where both valids are 1 and stall = 0.
- Saturates at all ones and does not wrap.
- stall cycles are not counted.

Same address from both requesters in the same cycle:
- Serialized like any other conflict.
- The later grant lands one or more cycles later, so the last grant wins in the register.

## Timing
- Reset (reset = 0, asynchronous): wr_valid = 0, wr_addr = 0, wr_data = 0, prio = 0, conflict_count = 0.
  - Consequently load_vec = 0, data_out = 0, fwd_valid = 0 and fwd_addr = 0 immediately, without waiting for a clock.
  - Both ready = 0 while reset = 0.
- Reset mid-operation: any write in the stage is discarded and never reaches the register bank. Requesters re-present after reset is released.
- Latency:
  - Transfer sampled at edge k.
  - load_vec and data_out are valid during cycle k+1.
  - The register bank captures at edge k+1.
- Throughput: one write per cycle sustained. Back-to-back grants produce consecutive load_vec pulses with no bubble.
- Two continuously valid requesters alternate grants every cycle, starting with requester 0 after reset.
- stall asserted at edge k: no transfer at k, so load_vec = 0 in cycle k+1. A write already in the stage still completes.

## Test plan
- Reset behaviour: drive reset = 0 mid-cycle while wr_valid = 1 -> load_vec, data_out and fwd_valid are 0 immediately; conflict_count = 0; both ready = 0.
- Single requester: req0 writes addr 5, data 0xDEADBEEF at edge k -> req0_ready = 1 in that cycle; in cycle k+1 load_vec = 0x00000020, data_out = 0xDEADBEEF, fwd_valid = 1, fwd_addr = 5.
- Round robin: both requesters held valid for 4 cycles after reset -> grant order 0,1,0,1; conflict_count = 4; no cycle has both ready high.
- x0 write: req1 writes addr 0, data 0x1 -> req1_ready = 1; next cycle load_vec = 0 and fwd_valid = 0.
- Stall: both valid with stall = 1 for 3 cycles, then stall = 0 -> no readies and conflict_count unchanged during the stall; prio unchanged; req0 is granted first afterwards.
- Counter saturation (CNTSIZE = 4): 20 contention cycles -> conflict_count stops at 15 and does not wrap.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the integer register file write port between two
// writeback requesters, with a registered write stage, forwarding tap and contention counter.
module regfile_write_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int ADDRSIZE = 5,
  parameter int NREGS    = 32,
  parameter int CNTSIZE  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                req0_valid,
  input  logic [ADDRSIZE-1:0] req0_addr,
  input  logic [WORDSIZE-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDRSIZE-1:0] req1_addr,
  input  logic [WORDSIZE-1:0] req1_data,
  output logic                req1_ready,
  output logic [NREGS-1:0]    load_vec,
  output logic [WORDSIZE-1:0] data_out,
  output logic                fwd_valid,
  output logic [ADDRSIZE-1:0] fwd_addr,
  output logic [CNTSIZE-1:0]  conflict_count
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

  prio_t                prio;
  prio_t                prio_next;
  logic                 contend;
  logic                 grant0;
  logic                 grant1;
  logic                 wr_valid;
  logic                 wr_nonzero;
  logic [ADDRSIZE-1:0]  wr_addr;
  logic [WORDSIZE-1:0]  wr_data;

  // Grants are gated by reset so neither requester sees ready while held in reset.
  always_comb begin
    contend   = req0_valid && req1_valid && !stall;
    grant0    = reset && !stall && req0_valid && (!req1_valid || (prio == PRIO_REQ0));
    grant1    = reset && !stall && req1_valid && (!req0_valid || (prio == PRIO_REQ1));
    prio_next = prio;
    if (contend) begin
      prio_next = (prio == PRIO_REQ0) ? PRIO_REQ1 : PRIO_REQ0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= PRIO_REQ0;
    end else begin
      prio <= prio_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_count <= '0;
    end else if (contend && (conflict_count != {CNTSIZE{1'b1}})) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end

  // Address and data hold when idle so data_out stays stable between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (grant0) begin
      wr_valid <= 1'b1;
      wr_addr  <= req0_addr;
      wr_data  <= req0_data;
    end else if (grant1) begin
      wr_valid <= 1'b1;
      wr_addr  <= req1_addr;
      wr_data  <= req1_data;
    end else begin
      wr_valid <= 1'b0;
    end
  end

  assign wr_nonzero = (wr_addr != '0);

  // x0 is hardwired: a write to it is accepted but never strobes a register.
  always_comb begin
    load_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      load_vec[i] = wr_valid && wr_nonzero && (wr_addr == ADDRSIZE'(i));
    end
  end

  assign data_out  = wr_data;
  assign fwd_valid = wr_valid && wr_nonzero;
  assign fwd_addr  = wr_addr;

endmodule
